// File: rtl/apb_rr_arbiter.sv
// Round-robin front end that lets NREQ requesters share a single APB completer.
// The winner's fields are latched on grant, then one SETUP/ACCESS transfer runs with an optional timeout.
module apb_rr_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [ADDR_W-1:0]        PADDR,
  output logic [DATA_W-1:0]        PWDATA,
  input  logic [DATA_W-1:0]        PRDATA,
  input  logic                     PREADY
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort happens on the edge that would make the wait count equal TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [NREQ-1:0]     r_owner_oh;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [NREQ-1:0]     r_gnt;
  logic [NREQ-1:0]     r_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;

  logic [ADDR_W-1:0]   w_addr  [NREQ];
  logic [DATA_W-1:0]   w_wdata [NREQ];
  logic                w_any;
  logic [PTR_W-1:0]    w_win_idx;
  logic [PTR_W-1:0]    w_cand;
  logic [PTR_W-1:0]    w_ptr_next;
  logic [NREQ-1:0]     w_win_oh;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan downward so the candidate closest to r_ptr is the last to overwrite the winner.
  always_comb begin
    w_any     = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = PTR_W'((int'(r_ptr) + k) % NREQ);
      if (req[w_cand]) begin
        w_any     = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  assign w_win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
  assign w_ptr_next = (w_win_idx == PTR_W'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_owner_oh <= '0;
      r_wait_cnt <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner_oh <= w_win_oh;
            r_gnt      <= w_win_oh;
            r_ptr      <= w_ptr_next;
            r_pwrite   <= req_write[w_win_idx];
            r_paddr    <= w_addr[w_win_idx];
            r_pwdata   <= w_wdata[w_win_idx];
            r_psel     <= 1'b1;
            r_penable  <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_done    <= r_owner_oh;
            r_err     <= 1'b0;
            if (!r_pwrite) begin
              r_rdata <= PRDATA;
            end
            r_state   <= ST_IDLE;
          end else if ((TIMEOUT != 0) && (r_wait_cnt == CNT_LAST)) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_done    <= r_owner_oh;
            r_err     <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign err     = r_err;
  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign PWRITE  = r_pwrite;
  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scoreboard bench for apb_rr_arbiter: grant and done expectations are queued as requests
// are driven, then popped and compared by a negedge monitor as the DUT produces them.
module tb_apb_rr_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 16;

  logic               PCLK = 1'b0;
  logic               PRESET = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    req_write = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               err;
  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [AW-1:0]      PADDR;
  logic [DW-1:0]      PWDATA;
  logic [DW-1:0]      PRDATA = '0;
  logic               PREADY = 1'b0;

  apb_rr_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          id;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    int          id;
    bit          err;
    logic [31:0] rdata;
    int          lat;
    int          pen;
  } dexp_t;

  gexp_t       gq[$];
  dexp_t       dq[$];
  logic [31:0] model_rdata = '0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          wait_cycles = 0;
  int          acc_cnt = 0;
  int          cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_edge();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push_gnt(input int id, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    gexp_t g;
    g.id = id; g.wr = wr; g.addr = addr; g.wdata = wdata;
    gq.push_back(g);
  endtask

  task automatic push_exp(input int id, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] prd, input int nwait);
    dexp_t d;
    bit    to;
    to = (nwait >= TMO);
    push_gnt(id, wr, addr, wdata);
    if (!to && !wr) model_rdata = prd;
    d.id    = id;
    d.err   = to;
    d.rdata = model_rdata;
    d.lat   = to ? TMO + 1 : nwait + 2;
    d.pen   = to ? TMO : nwait + 1;
    dq.push_back(d);
  endtask

  task automatic xfer(input int id, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] prd, input int nwait, output int gnt_lat);
    bit seen;
    push_exp(id, wr, addr, wdata, prd, nwait);
    PRDATA      = prd;
    wait_cycles = nwait;
    req_write[id]          = wr;
    req_addr[id*AW +: AW]  = addr;
    req_wdata[id*DW +: DW] = wdata;
    req[id]     = 1'b1;
    gnt_lat     = 0;
    seen        = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      wait_edge();
      if (gnt[id]) begin
        seen    = 1'b1;
        gnt_lat = n;
      end
    end
    req[id] = 1'b0;
    check("gnt_seen", 64'(seen), 64'(1));
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      wait_edge();
      if (done[id]) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'(1));
  endtask

  // Completer model: PREADY rises after wait_cycles ACCESS cycles.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      PREADY = (acc_cnt >= wait_cycles);
      acc_cnt++;
    end else begin
      PREADY  = 1'b0;
      acc_cnt = 0;
    end
  end

  always @(posedge PCLK) cyc++;

  gexp_t cur_g;
  dexp_t cur_d;
  bit    have_cur = 1'b0;
  int    gnt_cyc = 0;
  int    psel_cnt = 0;
  int    pen_cnt = 0;

  always @(negedge PCLK) begin
    if (!PRESET) begin
      have_cur = 1'b0;
      psel_cnt = 0;
      pen_cnt  = 0;
    end else begin
      check("pen_wo_sel", 64'(PENABLE & ~PSEL), '0);
      check("gnt_multi", 64'($countones(gnt) > 1), '0);
      check("done_multi", 64'($countones(done) > 1), '0);
      if (gnt != '0) begin
        if (gq.size() == 0) begin
          check("gnt_unexp", 64'(gnt), '0);
        end else begin
          cur_g    = gq.pop_front();
          have_cur = 1'b1;
          gnt_cyc  = cyc;
          psel_cnt = 0;
          pen_cnt  = 0;
          check("gnt_id", 64'(gnt), 64'(1 << cur_g.id));
          check("setup_sel_en", 64'({PSEL, PENABLE}), 64'(2'b10));
        end
      end
      if (PSEL && have_cur) begin
        psel_cnt++;
        if (PENABLE) pen_cnt++;
        check("paddr", 64'(PADDR), 64'(cur_g.addr));
        check("pwdata", 64'(PWDATA), 64'(cur_g.wdata));
        check("pwrite", 64'(PWRITE), 64'(cur_g.wr));
      end
      if (done != '0) begin
        if (dq.size() == 0) begin
          check("done_unexp", 64'(done), '0);
        end else begin
          cur_d = dq.pop_front();
          $display("xfer req%0d err=%0d rdata=%08h lat=%0d psel=%0d pen=%0d",
                   cur_d.id, err, rdata, cyc - gnt_cyc, psel_cnt, pen_cnt);
          check("done_id", 64'(done), 64'(1 << cur_d.id));
          check("err", 64'(err), 64'(cur_d.err));
          check("rdata", 64'(rdata), 64'(cur_d.rdata));
          check("latency", 64'(cyc - gnt_cyc), 64'(cur_d.lat));
          check("penable_cycles", 64'(pen_cnt), 64'(cur_d.pen));
          check("psel_cycles", 64'(psel_cnt), 64'(cur_d.pen + 1));
          check("psel_after_done", 64'({PSEL, PENABLE}), '0);
        end
        have_cur = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    int raised[2];
    bit seen;

    repeat (3) @(posedge PCLK);
    #1;
    check("rst_ctrl", 64'({gnt, done, err, PSEL, PENABLE, PWRITE}), '0);
    check("rst_rdata", 64'(rdata), '0);
    PRESET = 1'b1;

    // Both requesters contend; each is re-raised once after its own done.
    wait_cycles = 0;
    PRDATA      = 32'hDEAD_0000;
    req_write   = 2'b11;
    req_addr    = {32'h0000_0024, 32'h0000_0020};
    req_wdata   = {32'h0000_00B1, 32'h0000_00A0};
    for (int k = 0; k < 4; k++)
      push_exp(k % 2, 1'b1, (k % 2) ? 32'h24 : 32'h20, (k % 2) ? 32'hB1 : 32'hA0, 32'h0, 0);
    raised[0] = 1;
    raised[1] = 1;
    req   = 2'b11;
    ndone = 0;
    for (int c = 0; c < 60 && ndone < 4; c++) begin
      wait_edge();
      for (int i = 0; i < 2; i++) if (gnt[i]) req[i] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (done[i]) begin
          ndone++;
          if (raised[i] < 2) begin
            req[i] = 1'b1;
            raised[i]++;
          end
        end
      end
    end
    req = '0;
    check("rr_dones", 64'(ndone), 64'(4));

    xfer(0, 1'b1, 32'h0, 32'h5, 32'h0, 0, lat);
    check("zero_wait_gnt_lat", 64'(lat), 64'(1));
    xfer(1, 1'b0, 32'h4, 32'h0, 32'h3F80_0000, 0, lat);
    xfer(0, 1'b1, 32'h8, 32'hAA, 32'h0, 3, lat);
    xfer(1, 1'b0, 32'hC, 32'h0, 32'h0000_CAFE, TMO - 1, lat);
    xfer(1, 1'b0, 32'h18, 32'h0, 32'h0BAD_0BAD, 1000, lat);
    xfer(0, 1'b0, 32'h14, 32'h0, 32'h1234_5678, 0, lat);

    // Reset in the middle of a stalled ACCESS phase.
    wait_cycles = 1000;
    PRDATA      = 32'h0;
    req_write[0]      = 1'b1;
    req_addr[31:0]    = 32'h10;
    req_wdata[31:0]   = 32'h77;
    push_gnt(0, 1'b1, 32'h10, 32'h77);
    req[0] = 1'b1;
    seen   = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      wait_edge();
      if (gnt[0]) seen = 1'b1;
    end
    req[0] = 1'b0;
    check("abort_gnt_seen", 64'(seen), 64'(1));
    repeat (3) wait_edge();
    check("abort_in_access", 64'({PSEL, PENABLE}), 64'(2'b11));
    PRESET = 1'b0;
    #1;
    check("abort_ctrl_zero", 64'({gnt, done, err, PSEL, PENABLE, PWRITE}), '0);
    check("abort_paddr_zero", 64'(PADDR), '0);
    check("abort_pwdata_zero", 64'(PWDATA), '0);
    check("abort_rdata_zero", 64'(rdata), '0);
    model_rdata = '0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET      = 1'b1;
    wait_cycles = 0;
    req_write   = 2'b11;
    req_addr    = {32'h0000_0034, 32'h0000_0030};
    req_wdata   = {32'h0000_0011, 32'h0000_0010};
    push_exp(0, 1'b1, 32'h30, 32'h10, 32'h0, 0);
    push_exp(1, 1'b1, 32'h34, 32'h11, 32'h0, 0);
    req   = 2'b11;
    ndone = 0;
    for (int c = 0; c < 40 && ndone < 2; c++) begin
      wait_edge();
      for (int i = 0; i < 2; i++) if (gnt[i]) req[i] = 1'b0;
      for (int i = 0; i < 2; i++) if (done[i]) ndone++;
    end
    req = '0;
    check("post_reset_dones", 64'(ndone), 64'(2));

    repeat (4) wait_edge();
    check("gnt_queue_left", 64'(gq.size()), '0);
    check("done_queue_left", 64'(dq.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
